bf16_result_fifo: RTL and testbench
===================================

# bf16_result_fifo

Result-capture buffer that sits directly downstream of the bfloat16 `fpu`. Each cycle it can accept one 16-bit result (`out_o`), its overflow flag (`overflow_o`) and the one-hot mode that produced it. It buffers these in a show-ahead FIFO and drains them over a valid/ready interface to the consumer (result writer or bus bridge). It also keeps overflow and drop statistics for the datapath.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH)+1`, width of the occupancy count.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid_i`  in  1  result on `res_i` is valid this cycle.
- `res_i`  in  16  bfloat16 result from `fpu.out_o`.
- `ovf_i`  in  1  overflow flag from `fpu.overflow_o`.
- `mode_i`  in  4  mode tag (0001 add, 0010 sub, 0100 mul, 1000 div), stored unmodified.
- `out_valid_o`  out  1  head entry available.
- `out_ready_i`  in  1  consumer accepts head this cycle.
- `out_data_o`  out  16  head result.
- `out_ovf_o`  out  1  head overflow flag.
- `out_mode_o`  out  4  head mode tag.
- `count_o`  out  CNT_W  occupancy, 0..DEPTH.
- `full_o`  out  1  `count_o == DEPTH`.
- `empty_o`  out  1  `count_o == 0`.
- `drop_o`  out  1  registered one-cycle pulse: a push was rejected last cycle.
- `drop_cnt_o`  out  8  rejected pushes, saturating at 8'hFF.
- `ovf_cnt_o`  out  16  accepted entries with overflow set, saturating at 16'hFFFF.
- `sticky_ovf_o`  out  1  set by any accepted entry with overflow set.
- `clr_i`  in  1  synchronous clear of statistics only.

## Operation
- Storage is an array of DEPTH × 21 bits: {mode, ovf, data}.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally at DEPTH−1 → 0.
  - Occupancy is a separate CNT_W counter.
- pop = `out_valid_o & out_ready_i`.
- push = `in_valid_i & (!full_o | pop)`. When full, a simultaneous pop frees the slot, so both happen. Count is unchanged and both pointers advance.
- drop = `in_valid_i & full_o & !pop`. The input is discarded, `drop_o` is asserted the next cycle, and `drop_cnt_o` increments. `ovf_cnt_o` and `sticky_ovf_o` are not affected by a dropped entry.
- Empty with `in_valid_i` and `out_ready_i` both high: the push only. There is no bypass, and `out_valid_o` stays low this cycle.
- Head outputs are show-ahead: `out_data_o`, `out_ovf_o` and `out_mode_o` reflect `mem[rd_ptr]` whenever `out_valid_o` is high. When empty they are forced to 0.
- `out_valid_o = !empty_o`. Once asserted, the head stays stable until it is popped.
- Statistics update on an accepted push with `ovf_i = 1`:
  - `ovf_cnt_o` increments (saturating).
  - `sticky_ovf_o` is set.
- `clr_i` takes priority over updates in the same cycle. It zeroes `ovf_cnt_o`, `drop_cnt_o` and `sticky_ovf_o`, and a push with overflow in that cycle is not counted. FIFO contents and pointers are untouched.
- Mode tags are not checked; a non-one-hot tag is stored and returned as-is.

## Timing
- Reset values:
  - `out_valid_o` 0, `out_data_o` 16'h0000, `out_ovf_o` 0, `out_mode_o` 4'h0.
  - `count_o` 0, `full_o` 0, `empty_o` 1, `drop_o` 0.
  - `drop_cnt_o` 0, `ovf_cnt_o` 0, `sticky_ovf_o` 0.
  - Both pointers 0.
- Reset asserted mid-operation flushes all entries at that edge. Inputs in that cycle are ignored.
- Latency: a push at edge k gives `out_valid_o` high and valid head data after edge k.
- Pop at edge k exposes the next entry after edge k, giving sustained throughput of one per cycle.
- `count_o`, `full_o` and `empty_o` are registered and change only at clock edges.
- `drop_o` is high for exactly one cycle per rejected push. Back-to-back drops hold it high on consecutive cycles.

## Test plan
- Fill/drain ordering: push 8 entries (res 16'h3F80, 16'h4000, …, ovf 0, mode 0001) with `out_ready_i = 0`.
  - `full_o = 1`, `count_o = 8`.
  - Then assert ready: the 8 entries drain in order, one per cycle, ending with `empty_o = 1` and `out_data_o = 0`.
- Overflow on full: while full, push 16'h7F80 with ovf 1 and no pop.
  - `drop_o` pulses once and `drop_cnt_o = 1`.
  - `ovf_cnt_o` stays 0 and the FIFO contents are unchanged.
- Simultaneous push/pop when full: push 16'h4040 while popping.
  - `count_o` stays 8 and there is no drop.
  - 16'h4040 emerges 8 pops later, after the write pointer has wrapped.
- Statistics: 3 accepted pushes with ovf 1 give `ovf_cnt_o = 3` and `sticky_ovf_o = 1`.
  - `clr_i` together with a 4th ovf push gives counters 0 and sticky 0.
  - The 4th entry is still stored with `out_ovf_o = 1`.
- Empty push+pop: from empty, assert `in_valid_i` and `out_ready_i` together with res 16'hC000.
  - `out_valid_o` is 0 that cycle.
  - Next cycle `out_data_o = 16'hC000` and it pops.
- Reset mid-stream: with 5 entries held, assert `rst` for one cycle. All outputs return to their reset values, and a subsequent push appears after one cycle.

Source files
------------

// File: rtl/bf16_result_fifo.sv
// Show-ahead capture FIFO for bfloat16 FPU results with overflow/drop statistics.
// Push visible at head one edge later; when full, pushes are dropped unless a pop frees the slot that cycle.
module bf16_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [15:0]      res_i,
  input  logic             ovf_i,
  input  logic [3:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic             out_ovf_o,
  output logic [3:0]       out_mode_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [7:0]       drop_cnt_o,
  output logic [15:0]      ovf_cnt_o,
  output logic             sticky_ovf_o,
  input  logic             clr_i
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [20:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [20:0]      head;
  logic             push;
  logic             pop;
  logic             drop;

  assign empty_o     = (count == '0);
  assign full_o      = (count == CNT_W'(DEPTH));
  assign count_o     = count;
  assign out_valid_o = !empty_o;

  assign pop  = out_valid_o & out_ready_i;
  // A pop on a full FIFO frees the slot the same cycle, so the push still lands.
  assign push = in_valid_i & (!full_o | pop);
  assign drop = in_valid_i & full_o & !pop;

  assign head       = mem[rd_ptr];
  assign out_data_o = empty_o ? 16'h0000 : head[15:0];
  assign out_ovf_o  = empty_o ? 1'b0     : head[16];
  assign out_mode_o = empty_o ? 4'h0     : head[20:17];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {mode_i, ovf_i, res_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Statistics: clear wins over any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_o       <= 1'b0;
      drop_cnt_o   <= 8'h00;
      ovf_cnt_o    <= 16'h0000;
      sticky_ovf_o <= 1'b0;
    end else begin
      drop_o <= drop;
      if (clr_i) begin
        drop_cnt_o   <= 8'h00;
        ovf_cnt_o    <= 16'h0000;
        sticky_ovf_o <= 1'b0;
      end else begin
        if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'h01;
        if (push && ovf_i) begin
          sticky_ovf_o <= 1'b1;
          if (ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'h0001;
        end
      end
    end
  end

endmodule

// File: tb/tb_bf16_result_fifo.sv
// Bench for bf16_result_fifo: directed vector table, hand corner sequences, and a queue-based model.
module tb_bf16_result_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid_i;
  logic [15:0]      res_i;
  logic             ovf_i;
  logic [3:0]       mode_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [15:0]      out_data_o;
  logic             out_ovf_o;
  logic [3:0]       out_mode_o;
  logic [CNT_W-1:0] count_o;
  logic             full_o;
  logic             empty_o;
  logic             drop_o;
  logic [7:0]       drop_cnt_o;
  logic [15:0]      ovf_cnt_o;
  logic             sticky_ovf_o;
  logic             clr_i;

  always #5 clk = ~clk;

  bf16_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .res_i(res_i), .ovf_i(ovf_i),
    .mode_i(mode_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ovf_o(out_ovf_o), .out_mode_o(out_mode_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .drop_o(drop_o),
    .drop_cnt_o(drop_cnt_o), .ovf_cnt_o(ovf_cnt_o), .sticky_ovf_o(sticky_ovf_o),
    .clr_i(clr_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the FIFO is a plain queue of {mode, ovf, data}.
  logic [20:0] mq[$];
  int          m_drop_cnt;
  int          m_ovf_cnt;
  bit          m_sticky;
  bit          m_drop;

  typedef struct {
    logic        vld;
    logic [15:0] res;
    logic        ovf;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_data;
    logic [3:0]  e_count;
    logic        e_drop;
    logic [7:0]  e_dcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [15:0] r, logic o, logic rd,
                              logic ev, logic [15:0] ed, logic [3:0] ec, logic edr, logic [7:0] edc);
    vec_t t;
    t.vld = v; t.res = r; t.ovf = o; t.rdy = rd;
    t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_drop = edr; t.e_dcnt = edc;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [20:0] h;
    h = (mq.size() != 0) ? mq[0] : 21'h0;
    check("model",
          {1'b0, out_valid_o, out_mode_o, out_ovf_o, out_data_o, count_o, full_o, empty_o,
           drop_o, drop_cnt_o, ovf_cnt_o, sticky_ovf_o},
          {1'b0, mq.size() != 0, h, 4'(mq.size()), mq.size() == DEPTH, mq.size() == 0,
           m_drop, 8'(m_drop_cnt), 16'(m_ovf_cnt), m_sticky});
  endtask

  // Apply one cycle of inputs, check the pre-edge state, then advance the model past the edge.
  task automatic step(input logic r, input logic v, input logic [15:0] d, input logic o,
                      input logic [3:0] m, input logic rdy, input logic c);
    bit do_pop, do_push, do_drop;
    rst = r; in_valid_i = v; res_i = d; ovf_i = o; mode_i = m; out_ready_i = rdy; clr_i = c;
    #3;
    check_model();
    do_pop  = (mq.size() != 0) && rdy;
    do_push = v && (mq.size() != DEPTH || do_pop);
    do_drop = v && (mq.size() == DEPTH) && !do_pop;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_drop_cnt = 0; m_ovf_cnt = 0; m_sticky = 0; m_drop = 0;
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({m, o, d});
      m_drop = do_drop;
      if (c) begin
        m_drop_cnt = 0; m_ovf_cnt = 0; m_sticky = 0;
      end else begin
        if (do_drop && m_drop_cnt < 255) m_drop_cnt++;
        if (do_push && o) begin
          m_sticky = 1;
          if (m_ovf_cnt < 65535) m_ovf_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {out_valid_o, out_data_o, out_ovf_o, out_mode_o, count_o, full_o, empty_o,
                 drop_o, drop_cnt_o, ovf_cnt_o, sticky_ovf_o},
                {1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0});
  endtask

  initial begin
    logic [15:0] vals [8];
    vals = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0, 16'h4100};

    // Fill, drop on full, push+pop on full, then drain past the wrapped entry.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, vals[i], 0, 0, 1, 16'h3F80, 4'(i + 1), 0, 8'd0));
    tbl.push_back(mk(1, 16'h7F80, 1, 0, 1, 16'h3F80, 4'd8, 1, 8'd1));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h3F80, 4'd8, 0, 8'd1));
    tbl.push_back(mk(1, 16'h4040, 0, 1, 1, 16'h4000, 4'd8, 0, 8'd1));
    for (int i = 2; i < 8; i++) tbl.push_back(mk(0, 16'h0000, 0, 1, 1, vals[i], 4'(9 - i), 0, 8'd1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h4040, 4'd1, 0, 8'd1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0000, 4'd0, 0, 8'd1));

    rst = 1; in_valid_i = 0; res_i = 0; ovf_i = 0; mode_i = 0; out_ready_i = 0; clr_i = 0;
    @(posedge clk); #1;
    mq.delete(); m_drop_cnt = 0; m_ovf_cnt = 0; m_sticky = 0; m_drop = 0;
    check_reset_vals("reset_vals");

    foreach (tbl[i]) begin
      step(0, tbl[i].vld, tbl[i].res, tbl[i].ovf, 4'b0001, tbl[i].rdy, 0);
      check($sformatf("vec%0d", i),
            {out_valid_o, out_data_o, count_o, drop_o, drop_cnt_o, ovf_cnt_o},
            {tbl[i].e_valid, tbl[i].e_data, tbl[i].e_count, tbl[i].e_drop, tbl[i].e_dcnt, 16'h0000});
    end

    // Statistics and clear-priority.
    for (int i = 0; i < 3; i++) step(0, 1, 16'h4200 + 16'(i), 1, 4'b0100, 0, 0);
    check("stats_3ovf", {ovf_cnt_o, sticky_ovf_o}, {16'd3, 1'b1});
    step(0, 1, 16'h4300, 1, 4'b1000, 0, 1);
    check("stats_clr", {ovf_cnt_o, drop_cnt_o, sticky_ovf_o, count_o}, {16'd0, 8'd0, 1'b0, 4'd4});
    for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 0, 4'h0, 1, 0);
    check("stats_4th_head", {out_valid_o, out_data_o, out_ovf_o, out_mode_o}, {1'b1, 16'h4300, 1'b1, 4'b1000});
    step(0, 0, 16'h0, 0, 4'h0, 1, 0);

    // Empty push+pop: no bypass.
    rst = 0; in_valid_i = 1; res_i = 16'hC000; ovf_i = 0; mode_i = 4'b0010; out_ready_i = 1; #1;
    check("empty_pp_novalid", {out_valid_o, out_data_o}, {1'b0, 16'h0000});
    step(0, 1, 16'hC000, 0, 4'b0010, 1, 0);
    check("empty_pp_next", {out_valid_o, out_data_o, count_o}, {1'b1, 16'hC000, 4'd1});
    step(0, 0, 16'h0, 0, 4'h0, 1, 0);
    check("empty_pp_popped", {out_valid_o, empty_o}, {1'b0, 1'b1});

    // Reset mid-stream with 5 entries held and an input presented in the reset cycle.
    for (int i = 0; i < 5; i++) step(0, 1, 16'h5000 + 16'(i), 1, 4'b0001, 0, 0);
    step(1, 1, 16'hBEEF, 1, 4'b0100, 1, 0);
    check_reset_vals("midrst_vals");
    step(0, 1, 16'hD000, 0, 4'b1000, 0, 0);
    check("midrst_push", {out_valid_o, out_data_o, out_mode_o, count_o}, {1'b1, 16'hD000, 4'b1000, 4'd1});

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 16'($urandom),
           1'($urandom), 4'($urandom), (i % 64 < 32) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           $urandom_range(0, 40) == 0);
    end
    check_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
